// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the 32-bit RISC datapath: sequences
// fetch/decode/execute/memory/writeback, drives mux selects, write strobes and ALU op.
module multicycle_control #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  input  logic           zero,
  input  logic           flag,
  input  logic           mem_ready,
  output logic [2:0]     ALUControl,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           RegWrite,
  output logic           PCEn,
  output logic [1:0]     PCSource,
  output logic           exception,
  output logic [STW-1:0] state
);

  localparam logic [STW-1:0] FETCH   = STW'(0);
  localparam logic [STW-1:0] DECODE  = STW'(1);
  localparam logic [STW-1:0] MEMADR  = STW'(2);
  localparam logic [STW-1:0] MEMRD   = STW'(3);
  localparam logic [STW-1:0] MEMWB   = STW'(4);
  localparam logic [STW-1:0] MEMWR   = STW'(5);
  localparam logic [STW-1:0] EXEC    = STW'(6);
  localparam logic [STW-1:0] ALUWB   = STW'(7);
  localparam logic [STW-1:0] BEQ     = STW'(8);
  localparam logic [STW-1:0] ADDI_EX = STW'(9);
  localparam logic [STW-1:0] ADDI_WB = STW'(10);
  localparam logic [STW-1:0] JUMP    = STW'(11);
  localparam logic [STW-1:0] TRAP    = STW'(12);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

  localparam logic [OPW-1:0] FN_ADD = OPW'(6'b100000);
  localparam logic [OPW-1:0] FN_SUB = OPW'(6'b100010);
  localparam logic [OPW-1:0] FN_AND = OPW'(6'b100100);
  localparam logic [OPW-1:0] FN_OR  = OPW'(6'b100101);
  localparam logic [OPW-1:0] FN_SLT = OPW'(6'b101010);

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_LESS = 3'b111;

  logic [STW-1:0] state_q, state_d;
  logic           ovf_q, ovf_d;
  logic [2:0]     exec_alu;
  logic           exec_legal;
  logic           exec_arith;

  // R-type funct decode shared by next-state and output logic
  always_comb begin
    exec_alu   = ALU_ADD;
    exec_legal = 1'b1;
    exec_arith = 1'b0;
    case (funct)
      FN_ADD:  begin exec_alu = ALU_ADD; exec_arith = 1'b1; end
      FN_SUB:  begin exec_alu = ALU_SUB; exec_arith = 1'b1; end
      FN_AND:  exec_alu = ALU_AND;
      FN_OR:   exec_alu = ALU_OR;
      FN_SLT:  exec_alu = ALU_LESS;
      default: exec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    case (state_q)
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BEQ;
          OP_ADDI:      state_d = ADDI_EX;
          OP_J:         state_d = JUMP;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR:  state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (mem_ready) state_d = MEMWB;
      MEMWB:   state_d = FETCH;
      MEMWR:   if (mem_ready) state_d = FETCH;
      EXEC: begin
        if (exec_legal) begin
          ovf_d   = exec_arith & flag;
          state_d = ALUWB;
        end else begin
          state_d = TRAP;
        end
      end
      ALUWB:   state_d = ovf_q ? TRAP : FETCH;
      BEQ:     state_d = FETCH;
      ADDI_EX: begin
        ovf_d   = flag;
        state_d = ADDI_WB;
      end
      ADDI_WB: state_d = ovf_q ? TRAP : FETCH;
      JUMP:    state_d = FETCH;
      default: state_d = TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  // Moore decode; reset low blanks every strobe and select combinationally
  always_comb begin
    ALUControl = ALU_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    PCEn       = 1'b0;
    PCSource   = 2'b00;
    exception  = 1'b0;
    if (reset) begin
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCEn    = mem_ready;
        end
        DECODE:  ALUSrcB = 2'b11;
        MEMADR:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        MEMRD:   begin MemRead = 1'b1; IorD = 1'b1; end
        MEMWB:   begin RegWrite = 1'b1; MemtoReg = 1'b1; end
        MEMWR:   begin MemWrite = 1'b1; IorD = 1'b1; end
        EXEC:    begin ALUSrcA = 1'b1; ALUControl = exec_alu; end
        ALUWB:   begin RegDst = 1'b1; RegWrite = ~ovf_q; end
        BEQ: begin
          ALUSrcA    = 1'b1;
          ALUControl = ALU_SUB;
          PCSource   = 2'b01;
          PCEn       = zero;
        end
        ADDI_EX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        ADDI_WB: RegWrite = ~ovf_q;
        JUMP:    begin PCSource = 2'b10; PCEn = 1'b1; end
        TRAP:    exception = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle traces built from the
// instruction class, wait counts and flag/zero values, checked every cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, flag, mem_ready;
  logic [2:0] ALUControl;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCEn;
  logic [1:0] PCSource;
  logic       exception;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control #(.OPW(6), .STW(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .flag(flag), .mem_ready(mem_ready), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .PCEn(PCEn), .PCSource(PCSource), .exception(exception), .state(state)
  );

  typedef struct packed {
    logic mr, mw, ir, rw, pe, iord, sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic rd, m2r;
    logic [1:0] ps;
    logic ex;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    logic mrdy, z, f;
    ctl_t e, m;
  } rec_t;

  ctl_t ctl;
  assign ctl = {MemRead, MemWrite, IRWrite, RegWrite, PCEn, IorD, ALUSrcA, ALUSrcB,
                ALUControl, RegDst, MemtoReg, PCSource, exception};

  int   n_cmp = 0;
  int   n_err = 0;
  rec_t q[$];
  bit   trapped;
  logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int alu_of(logic [5:0] fn);
    case (fn)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction

  function automatic bit legal_op(logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // Expected outputs per state; unstated selects are masked out, strobes never are
  function automatic rec_t mk(int st, logic mrdy, logic z, logic f, logic ov, int alux);
    rec_t r;
    r = '0;
    r.st = 4'(st); r.mrdy = mrdy; r.z = z; r.f = f;
    r.m.mr = 1'b1; r.m.mw = 1'b1; r.m.ir = 1'b1; r.m.rw = 1'b1; r.m.pe = 1'b1; r.m.ex = 1'b1;
    case (st)
      0: begin
        r.e.mr = 1'b1; r.e.ir = mrdy; r.e.pe = mrdy; r.e.sb = 2'b01; r.e.alu = 3'b010;
        r.m.iord = 1'b1; r.m.sa = 1'b1; r.m.sb = 2'b11; r.m.alu = 3'b111; r.m.ps = 2'b11;
      end
      1: begin
        r.e.sb = 2'b11; r.e.alu = 3'b010;
        r.m.sa = 1'b1; r.m.sb = 2'b11; r.m.alu = 3'b111;
      end
      2, 9: begin
        r.e.sa = 1'b1; r.e.sb = 2'b10; r.e.alu = 3'b010;
        r.m.sa = 1'b1; r.m.sb = 2'b11; r.m.alu = 3'b111;
      end
      3: begin r.e.mr = 1'b1; r.e.iord = 1'b1; r.m.iord = 1'b1; end
      4: begin r.e.rw = 1'b1; r.e.m2r = 1'b1; r.m.rd = 1'b1; r.m.m2r = 1'b1; end
      5: begin r.e.mw = 1'b1; r.e.iord = 1'b1; r.m.iord = 1'b1; end
      6: begin
        r.e.sa = 1'b1; r.m.sa = 1'b1; r.m.sb = 2'b11;
        if (alux >= 0) begin r.e.alu = 3'(alux); r.m.alu = 3'b111; end
      end
      7: begin r.e.rd = 1'b1; r.e.rw = ~ov; r.m.rd = 1'b1; r.m.m2r = 1'b1; end
      8: begin
        r.e.sa = 1'b1; r.e.alu = 3'b110; r.e.ps = 2'b01; r.e.pe = z;
        r.m.sa = 1'b1; r.m.sb = 2'b11; r.m.alu = 3'b111; r.m.ps = 2'b11;
      end
      10: begin r.e.rw = ~ov; r.m.rd = 1'b1; r.m.m2r = 1'b1; end
      11: begin r.e.ps = 2'b10; r.e.pe = 1'b1; r.m.ps = 2'b11; end
      12: r.e.ex = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  function automatic rec_t mk_rst();
    rec_t r;
    r = '0;
    r.e.alu = 3'b010;
    r.m = '1;
    return r;
  endfunction

  task automatic check(input rec_t r, input string tag);
    n_cmp++;
    assert (state === r.st) else begin
      n_err++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state, r.st);
    end
    n_cmp++;
    assert ((ctl & r.m) === (r.e & r.m)) else begin
      n_err++;
      $error("FAIL %s ctl in state %0d: observed %05h expected %05h (mask %05h)",
             tag, r.st, ctl & r.m, r.e & r.m, r.m);
    end
  endtask

  task automatic step(input rec_t r);
    mem_ready = r.mrdy; zero = r.z; flag = r.f;
    #1;
    check(r, "cycle");
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; mem_ready = 1'b1; zero = rb(); flag = rb();
    #1;
    check(mk_rst(), "reset_async");
    @(posedge clk); #1;
    check(mk_rst(), "reset_held");
    reset = 1'b1;
  endtask

  // kind: 0 R, 1 lw, 2 sw, 3 beq, 4 addi, 5 j, 6 illegal opcode, 7 illegal funct
  task automatic run_instr(input int kind, input logic [5:0] code, input int w0, input int w1,
                           input logic zf, input int ntrap, output bit trp);
    logic ov;
    int   ax;
    q.delete();
    trp = 1'b0;
    funct = 6'($urandom);
    case (kind)
      0, 7: begin opcode = 6'b000000; funct = code; end
      1: opcode = 6'b100011;
      2: opcode = 6'b101011;
      3: opcode = 6'b000100;
      4: opcode = 6'b001000;
      5: opcode = 6'b000010;
      default: opcode = code;
    endcase
    for (int i = 0; i < w0; i++) q.push_back(mk(0, 1'b0, rb(), rb(), 1'b0, -1));
    q.push_back(mk(0, 1'b1, rb(), rb(), 1'b0, -1));
    q.push_back(mk(1, rb(), rb(), rb(), 1'b0, -1));
    case (kind)
      0, 7: begin
        ax = alu_of(funct);
        q.push_back(mk(6, rb(), rb(), zf, 1'b0, ax));
        if (ax < 0) trp = 1'b1;
        else begin
          ov = (funct == 6'b100000 || funct == 6'b100010) ? zf : 1'b0;
          q.push_back(mk(7, rb(), rb(), rb(), ov, -1));
          trp = ov;
        end
      end
      1, 2: begin
        q.push_back(mk(2, rb(), rb(), rb(), 1'b0, -1));
        for (int i = 0; i < w1; i++) q.push_back(mk(kind == 1 ? 3 : 5, 1'b0, rb(), rb(), 1'b0, -1));
        q.push_back(mk(kind == 1 ? 3 : 5, 1'b1, rb(), rb(), 1'b0, -1));
        if (kind == 1) q.push_back(mk(4, rb(), rb(), rb(), 1'b0, -1));
      end
      3: q.push_back(mk(8, rb(), zf, rb(), 1'b0, -1));
      4: begin
        q.push_back(mk(9, rb(), rb(), zf, 1'b0, -1));
        q.push_back(mk(10, rb(), rb(), rb(), zf, -1));
        trp = zf;
      end
      5: q.push_back(mk(11, rb(), rb(), rb(), 1'b0, -1));
      default: trp = 1'b1;
    endcase
    if (trp) for (int i = 0; i < ntrap; i++) q.push_back(mk(12, rb(), rb(), rb(), 1'b0, -1));
    while (q.size() > 0) step(q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; flag = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Reset dropped while an add sits in EXEC
    opcode = 6'b000000; funct = 6'b100000;
    step(mk(0, 1'b1, 1'b0, 1'b0, 1'b0, -1));
    step(mk(1, 1'b1, 1'b0, 1'b0, 1'b0, -1));
    do_reset();
    step(mk(0, 1'b0, 1'b0, 1'b0, 1'b0, -1));
    step(mk(0, 1'b1, 1'b0, 1'b0, 1'b0, -1));
    step(mk(1, 1'b1, 1'b0, 1'b0, 1'b0, -1));
    step(mk(6, 1'b1, 1'b0, 1'b0, 1'b0, 2));
    step(mk(7, 1'b1, 1'b0, 1'b0, 1'b0, -1));

    run_instr(0, 6'b100010, 0, 0, 1'b0, 0, trapped);
    run_instr(1, 6'b000000, 0, 2, 1'b0, 0, trapped);
    run_instr(3, 6'b000000, 0, 0, 1'b1, 0, trapped);
    run_instr(3, 6'b000000, 0, 0, 1'b0, 0, trapped);
    run_instr(0, 6'b100000, 0, 0, 1'b1, 10, trapped);
    do_reset();
    run_instr(6, 6'b111111, 0, 0, 1'b0, 3, trapped);
    do_reset();
    run_instr(7, 6'b000000, 0, 0, 1'b0, 3, trapped);
    do_reset();

    for (int n = 0; n < 60; n++) begin
      int k;
      logic [5:0] c;
      k = $urandom_range(0, 7);
      c = legal_fn[$urandom_range(0, 4)];
      if (k == 6) begin
        c = 6'($urandom);
        while (legal_op(c)) c = 6'($urandom);
      end else if (k == 7) begin
        c = 6'($urandom);
        while (alu_of(c) >= 0) c = 6'($urandom);
      end
      run_instr(k, c, $urandom_range(0, 2), $urandom_range(0, 3),
                (k == 3) ? rb() : ($urandom_range(0, 3) == 0), $urandom_range(1, 3), trapped);
      if (trapped) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle main control FSM for the 32-bit RISC datapath.
- Drives the ALU's 3-bit ALUControl code and consumes the ALU's zero and flag (overflow) outputs.
- Sequences fetch, decode, execute, memory and writeback; issues all datapath mux selects and write strobes.
- Waits on a memory ready handshake and traps on illegal instructions or arithmetic overflow.

Parameters:
- OPW, 6, opcode and funct field width.
- STW, 4, width of the state encoding.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  6  instruction[31:26], taken from the instruction register.
- funct  input  6  instruction[5:0].
- zero  input  1  ALU zero output (data1 == data2).
- flag  input  1  ALU signed-overflow output.
- mem_ready  input  1  memory has completed the current read or write this cycle.
- ALUControl  output  3  ALU operation: 010 ADD, 110 SUB, 000 AND, 001 OR, 111 LESS.
- ALUSrcA  output  1  0 selects PC, 1 selects register A.
- ALUSrcB  output  2  00 B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2.
- IorD  output  1  memory address select: 0 PC, 1 ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- RegDst  output  1  destination register: 1 rd, 0 rt.
- MemtoReg  output  1  write-back data: 1 MDR, 0 ALUOut.
- RegWrite  output  1  register file write.
- PCEn  output  1  PC load.
- PCSource  output  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target.
- exception  output  1  trap taken; sticky until reset.
- state  output  4  current state, for debug.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH (0), ovf_q=0.
  - Every strobe (MemRead, MemWrite, IRWrite, RegWrite, PCEn) forced to 0 while reset=0.
  - All selects and ALUControl read 0, except ALUControl=010.
  - exception=0.
- Output style: all outputs are Moore decodes of state, with two exceptions:
  - IRWrite and PCEn in FETCH are gated by mem_ready.
  - PCEn in BEQ is gated by zero.
- States and transitions (codes 0–12):
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSource=00. IRWrite=PCEn=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUControl=ADD (branch target into ALUOut). Next state by opcode:
    - 100011 or 101011 -> MEMADR.
    - 000000 -> EXEC.
    - 000100 -> BEQ.
    - 001000 -> ADDI_EX.
    - 000010 -> JUMP.
    - any other opcode -> TRAP.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ADD. Goes to MEMRD if opcode=100011, else MEMWR.
  - MEMRD(3): MemRead=1, IorD=1. Holds until mem_ready=1, then goes to MEMWB.
  - MEMWB(4): RegWrite=1, RegDst=0, MemtoReg=1. Goes to FETCH.
  - MEMWR(5): MemWrite=1, IorD=1. Holds until mem_ready=1, then goes to FETCH.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00. funct maps to ALUControl as follows:
    - 100000 -> ADD.
    - 100010 -> SUB.
    - 100100 -> AND.
    - 100101 -> OR.
    - 101010 -> LESS.
    - any other funct -> TRAP, and ovf_q is not updated.
    - For a legal funct: ovf_q <= flag when funct is add or sub, else ovf_q <= 0. Then goes to ALUWB.
  - ALUWB(7): RegDst=1, MemtoReg=0. If ovf_q=1: RegWrite=0 and go to TRAP. Otherwise RegWrite=1 and go to FETCH.
  - BEQ(8): ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, PCEn=zero. Goes to FETCH.
  - ADDI_EX(9): ALUSrcA=1, ALUSrcB=10, ADD; ovf_q <= flag. Goes to ADDI_WB.
  - ADDI_WB(10): RegDst=0, MemtoReg=0. RegWrite=!ovf_q. Goes to TRAP if ovf_q, else FETCH.
  - JUMP(11): PCSource=10, PCEn=1. Goes to FETCH.
  - TRAP(12): exception=1, all strobes 0. Absorbing; only reset leaves TRAP.
- Latency with mem_ready always 1:
  - R-type 4 cycles, lw 5, sw 4, addi 4, beq 3, j 3.
  - Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Undefined state codes 13–15 go to TRAP.
- Reset mid-instruction: abandons the instruction immediately; no strobe is issued after reset falls. Restarts in FETCH on the first edge after reset rises.
- opcode and funct must be stable from DECODE to writeback; the FSM does not latch them.

Test Plan:
- Reset low mid-EXEC, then high -> state=0 and all strobes 0 during reset; first edge after release stays in FETCH, and with mem_ready=1 IRWrite=PCEn=1.
- R-type opcode=000000, funct=100010, mem_ready=1, flag=0 -> states 0,1,6,7,0; ALUControl=110 in EXEC; RegWrite=1, RegDst=1 in ALUWB.
- lw opcode=100011, mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles; MemRead=IorD=1 throughout; MEMWB has RegWrite=1, MemtoReg=1; total 7 cycles.
- beq opcode=000100 with zero=1 and then with zero=0 -> ALUControl=110 in BEQ; PCEn=1 and PCSource=01 when zero=1; PCEn=0 when zero=0.
- add with flag=1 in EXEC -> ALUWB has RegWrite=0; next state TRAP with exception=1, held for 10 cycles until reset.
- Illegal opcode=111111 -> DECODE then TRAP, exception=1; funct=000000 with R-type -> EXEC then TRAP.
